// File: rtl/keyfile_reader_if.sv
// openMSP430 peripheral bus bundle: the CPU drives address/data/enables,
// the peripheral returns read data combinationally in the same cycle.
interface keyfile_reader_if;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;

    modport master (
        output per_addr, per_din, per_en, per_we,
        input  per_dout
    );

    modport slave (
        input  per_addr, per_din, per_en, per_we,
        output per_dout
    );
endinterface

// File: rtl/keyfile_reader.sv
// Read-once keyfile shadow: snapshots the radio-side key, shifts it into a shadow
// register SHIFT_W bits per cycle, and zeroizes the shadow once every word is read.
module keyfile_reader #(
    parameter logic [14:0] BASE_ADDR = 15'h00B0,
    parameter int          DEC_WD    = 4,
    parameter int          SHIFT_W   = 4
) (
    input  logic              mclk,
    input  logic              puc_rst,
    keyfile_reader_if.slave   bus,
    input  logic              smclk_en,
    input  logic [63:0]       key_data_in,
    output logic              irq_key
);

    localparam int NSTEP = 64 / SHIFT_W;
    localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    localparam logic [DEC_WD-1:0] OFF_CTRL = DEC_WD'(4'h0);
    localparam logic [DEC_WD-1:0] OFF_STAT = DEC_WD'(4'h2);
    localparam logic [DEC_WD-1:0] OFF_KEY0 = DEC_WD'(4'h4);
    localparam logic [DEC_WD-1:0] OFF_KEY3 = DEC_WD'(4'hA);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_VALID = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [63:0]        capture_q, capture_d;
    logic [63:0]        shadow_q,  shadow_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               irq_en_q,  irq_en_d;
    logic               stale_q,   stale_d;
    logic [3:0]         rdmask_q,  rdmask_d;
    logic               irq_key_q, irq_key_d;

    // Bus decode
    logic              reg_sel, reg_wr, reg_rd, ctrl_wr, load_stb, clr_stb, key_rd;
    logic [DEC_WD-1:0] reg_off, key_rel;
    logic [1:0]        key_idx;
    logic [3:0]        rdmask_new;
    logic [15:0]       key_word, rd_data;
    logic [63:0]       cap_aligned;

    assign reg_sel  = bus.per_en & (bus.per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
    assign reg_off  = {bus.per_addr[DEC_WD-2:0], 1'b0};
    assign reg_wr   = reg_sel & (|bus.per_we);
    assign reg_rd   = reg_sel & ~(|bus.per_we);
    assign ctrl_wr  = reg_wr & (reg_off == OFF_CTRL);
    assign load_stb = ctrl_wr & bus.per_din[0];
    assign clr_stb  = ctrl_wr & bus.per_din[1];

    assign key_rd   = reg_rd & (reg_off >= OFF_KEY0) & (reg_off <= OFF_KEY3);
    assign key_rel  = reg_off - OFF_KEY0;
    assign key_idx  = key_rel[2:1];
    assign rdmask_new = rdmask_q | (4'b0001 << key_idx);

    // MSB-first slice of the frozen capture for the current transfer step
    assign cap_aligned = capture_q << (32'(cnt_q) * SHIFT_W);

    logic unused_ok;
    assign unused_ok = &{1'b0, smclk_en, bus.per_din[15:3]};

    always_comb begin
        case (key_idx)
            2'd0:    key_word = shadow_q[63:48];
            2'd1:    key_word = shadow_q[47:32];
            2'd2:    key_word = shadow_q[31:16];
            default: key_word = shadow_q[15:0];
        endcase
    end

    always_comb begin
        rd_data = 16'h0000;
        case (reg_off)
            OFF_CTRL: rd_data = {13'd0, irq_en_q, 2'b00};
            OFF_STAT: rd_data = {8'd0, rdmask_q, 1'b0, stale_q,
                                 state_q == ST_VALID, state_q == ST_LOAD};
            default:  if (key_rd && state_q == ST_VALID) rd_data = key_word;
        endcase
    end

    assign bus.per_dout = reg_rd ? rd_data : 16'h0000;
    assign irq_key      = irq_key_q;

    always_comb begin
        // NOTE: every _d gets a hold default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        capture_d = capture_q;
        shadow_d  = shadow_q;
        cnt_d     = cnt_q;
        irq_en_d  = ctrl_wr ? bus.per_din[2] : irq_en_q;
        stale_d   = stale_q;
        rdmask_d  = rdmask_q;
        irq_key_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_stb) begin
                    capture_d = key_data_in;
                    shadow_d  = 64'd0;
                    cnt_d     = '0;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shadow_d = {shadow_q[63-SHIFT_W:0], cap_aligned[63 -: SHIFT_W]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NSTEP - 1)) begin
                    state_d   = ST_VALID;
                    rdmask_d  = 4'h0;
                    stale_d   = 1'b0;
                    irq_key_d = irq_en_q;
                end
            end
            ST_VALID: begin
                if (key_data_in != capture_q) stale_d = 1'b1;
                if (key_rd) begin
                    if (rdmask_new == 4'hF) begin
                        shadow_d = 64'd0;
                        rdmask_d = 4'h0;
                        state_d  = ST_IDLE;
                    end else begin
                        rdmask_d = rdmask_new;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // CLR overrides everything, including a LOAD in the same write
        if (clr_stb) begin
            shadow_d  = 64'd0;
            capture_d = 64'd0;
            rdmask_d  = 4'h0;
            stale_d   = 1'b0;
            cnt_d     = '0;
            irq_key_d = 1'b0;
            state_d   = ST_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q   <= ST_IDLE;
            capture_q <= 64'd0;
            shadow_q  <= 64'd0;
            cnt_q     <= '0;
            irq_en_q  <= 1'b0;
            stale_q   <= 1'b0;
            rdmask_q  <= 4'h0;
            irq_key_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            capture_q <= capture_d;
            shadow_q  <= shadow_d;
            cnt_q     <= cnt_d;
            irq_en_q  <= irq_en_d;
            stale_q   <= stale_d;
            rdmask_q  <= rdmask_d;
            irq_key_q <= irq_key_d;
        end
    end

endmodule

// File: tb/tb_keyfile_reader.sv
// Scoreboard bench for keyfile_reader: reads push expected data, a negedge monitor
// pops and compares whenever a bus read is presented.
module tb_keyfile_reader;

    localparam logic [13:0] A_CTRL = 14'h58;
    localparam logic [13:0] A_STAT = 14'h59;
    localparam logic [13:0] A_KEY0 = 14'h5A;
    localparam logic [13:0] A_KEY1 = 14'h5B;
    localparam logic [13:0] A_KEY2 = 14'h5C;
    localparam logic [13:0] A_KEY3 = 14'h5D;
    localparam logic [13:0] A_OFFC = 14'h5E;
    localparam logic [13:0] A_OFFE = 14'h5F;

    logic        mclk = 1'b0;
    logic        puc_rst;
    logic        smclk_en;
    logic [63:0] key_data_in;
    logic        irq_key;

    int checks = 0;
    int errors = 0;
    int irq_count = 0;

    typedef struct {
        string       name;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];

    keyfile_reader_if bus ();

    keyfile_reader dut (
        .mclk        (mclk),
        .puc_rst     (puc_rst),
        .bus         (bus.slave),
        .smclk_en    (smclk_en),
        .key_data_in (key_data_in),
        .irq_key     (irq_key)
    );

    always #5 mclk = ~mclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // All bus tasks start and end at posedge+1, so consecutive calls are back-to-back cycles.
    task automatic rd(input string name, input logic [13:0] addr, input logic [15:0] exp);
        sb.push_back('{name, exp});
        bus.per_addr = addr;
        bus.per_we   = 2'b00;
        bus.per_en   = 1'b1;
        @(posedge mclk);
        #1;
        bus.per_en   = 1'b0;
    endtask

    task automatic wr(input logic [13:0] addr, input logic [15:0] data);
        bus.per_addr = addr;
        bus.per_din  = data;
        bus.per_we   = 2'b11;
        bus.per_en   = 1'b1;
        @(posedge mclk);
        #1;
        bus.per_en   = 1'b0;
        bus.per_we   = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge mclk);
            #1;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge mclk);
            if (irq_key === 1'b1) irq_count++;
            if (bus.per_en === 1'b1 && bus.per_we === 2'b00) begin
                if (sb.size() == 0) begin
                    check("unexpected_read", 64'(bus.per_dout), 64'hDEAD);
                end else begin
                    e = sb.pop_front();
                    check(e.name, 64'(bus.per_dout), 64'(e.data));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        puc_rst      = 1'b1;
        smclk_en     = 1'b0;
        key_data_in  = 64'h0123_4567_89AB_CDEF;
        bus.per_addr = '0;
        bus.per_din  = '0;
        bus.per_en   = 1'b0;
        bus.per_we   = 2'b00;
        repeat (3) @(posedge mclk);
        #1;
        puc_rst = 1'b0;

        // Reset state
        rd("rst_stat", A_STAT, 16'h0000);
        rd("rst_ctrl", A_CTRL, 16'h0000);
        rd("rst_key0", A_KEY0, 16'h0000);
        rd("rst_key1", A_KEY1, 16'h0000);
        rd("rst_key2", A_KEY2, 16'h0000);
        rd("rst_key3", A_KEY3, 16'h0000);
        check("rst_irq", 64'(irq_count), 64'd0);

        // Basic load with IRQ_EN, then read-once
        wr(A_CTRL, 16'h0005);
        for (int i = 0; i < 16; i++) rd("load_busy", A_STAT, 16'h0001);
        rd("load_done_stat", A_STAT, 16'h0002);
        check("load_irq_once", 64'(irq_count), 64'd1);
        rd("basic_key0", A_KEY0, 16'h0123);
        rd("basic_mask1", A_STAT, 16'h0012);
        rd("basic_key1", A_KEY1, 16'h4567);
        rd("basic_mask3", A_STAT, 16'h0032);
        rd("basic_key2", A_KEY2, 16'h89AB);
        rd("basic_mask7", A_STAT, 16'h0072);
        rd("basic_key3", A_KEY3, 16'hCDEF);
        rd("zeroize_stat", A_STAT, 16'h0000);
        rd("zeroize_key0", A_KEY0, 16'h0000);
        rd("zeroize_key3", A_KEY3, 16'h0000);
        rd("ctrl_irq_en", A_CTRL, 16'h0004);
        check("irq_still_once", 64'(irq_count), 64'd1);

        // Tear-proof capture: source changes on cycle 5 of LOAD, IRQ_EN now 0
        wr(A_CTRL, 16'h0001);
        idle(4);
        key_data_in = 64'hFFFF_FFFF_FFFF_FFFF;
        idle(11);
        rd("tear_last_busy", A_STAT, 16'h0001);
        idle(1);
        rd("tear_stat", A_STAT, 16'h0006);
        rd("tear_key0", A_KEY0, 16'h0123);
        rd("tear_key3", A_KEY3, 16'hCDEF);
        rd("tear_mask", A_STAT, 16'h0096);
        check("tear_no_irq", 64'(irq_count), 64'd1);

        // LOAD during VALID is ignored; data and RDMASK kept
        wr(A_CTRL, 16'h0001);
        idle(20);
        rd("valid_load_key1", A_KEY1, 16'h4567);
        rd("valid_load_stat", A_STAT, 16'h00B6);

        // CLR from VALID
        wr(A_CTRL, 16'h0002);
        rd("clr_stat", A_STAT, 16'h0000);
        rd("clr_key1", A_KEY1, 16'h0000);

        // Abort: CLR on cycle 8 of LOAD, no irq
        key_data_in = 64'h0123_4567_89AB_CDEF;
        wr(A_CTRL, 16'h0005);
        idle(7);
        wr(A_CTRL, 16'h0006);
        rd("abort_stat", A_STAT, 16'h0000);
        idle(20);
        rd("abort_stat_late", A_STAT, 16'h0000);
        check("abort_no_irq", 64'(irq_count), 64'd1);

        // Subsequent load completes normally
        key_data_in = 64'hDEAD_BEEF_CAFE_F00D;
        wr(A_CTRL, 16'h0005);
        idle(16);
        rd("reload_stat", A_STAT, 16'h0002);
        check("reload_irq", 64'(irq_count), 64'd2);

        // Partial read and address range
        rd("part_key2a", A_KEY2, 16'hCAFE);
        rd("part_key2b", A_KEY2, 16'hCAFE);
        rd("part_key0", A_KEY0, 16'hDEAD);
        rd("part_stat", A_STAT, 16'h0052);
        rd("off_c", A_OFFC, 16'h0000);
        rd("off_e", A_OFFE, 16'h0000);
        rd("out_range_hi", 14'h0060, 16'h0000);
        rd("out_range_lo", 14'h0050, 16'h0000);
        rd("part_key1", A_KEY1, 16'hBEEF);
        rd("part_stat2", A_STAT, 16'h0072);

        // LOAD+CLR in the same write from IDLE: stays IDLE
        wr(A_CTRL, 16'h0002);
        rd("conf_pre_stat", A_STAT, 16'h0000);
        wr(A_CTRL, 16'h0003);
        idle(20);
        rd("conf_stat", A_STAT, 16'h0000);
        check("conf_no_irq", 64'(irq_count), 64'd2);

        // Asynchronous reset in the middle of a load
        wr(A_CTRL, 16'h0005);
        idle(5);
        #2;
        puc_rst = 1'b1;
        rd("rst_mid_stat", A_STAT, 16'h0000);
        puc_rst = 1'b0;
        rd("post_rst_ctrl", A_CTRL, 16'h0000);
        rd("post_rst_stat", A_STAT, 16'h0000);
        idle(20);
        rd("post_rst_idle", A_STAT, 16'h0000);
        rd("post_rst_key0", A_KEY0, 16'h0000);
        check("post_rst_no_irq", 64'(irq_count), 64'd2);

        idle(2);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
